scc_mem_responder: RTL and testbench
====================================

Name: scc_mem_responder

Overview:
- Memory-side responder for the SCC core's two memory interfaces: the instruction-fetch port and the data load/store port.
- Holds a single word-addressed storage array shared by both ports.
- Answers fetches and loads with fixed 1-cycle registered latency and performs stores.
- Flags misaligned, out-of-range and read/write-collision accesses in a sticky fault register.
- Provides a preload port so the bench or boot logic can write the program image.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the storage array; power of two, >= 4.
- IDX_W, log2(DEPTH_WORDS) = 10, word-index width; byte address bits [IDX_W+1:2] select the word.

Ports:
- clk  input  1  main clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all registers except the storage array.
- in_mem_addr  input  32  byte address of the instruction fetch.
- in_mem_en  input  1  fetch request, sampled at the rising edge.
- in_mem  output  32  fetched instruction word, valid the cycle after the request.
- data_addr  input  32  byte address of the load or store.
- data_out  input  32  store data from the core.
- data_read  input  1  load request.
- data_write  input  1  store request.
- data_in  output  32  loaded data word, valid the cycle after the request.
- load_en  input  1  preload write strobe.
- load_addr  input  IDX_W  preload word index.
- load_data  input  32  preload word.
- fault_valid  output  1  sticky fault flag.
- fault_code  output  2  fault cause: 01 misaligned, 10 out of range, 11 read+write collision.
- fault_addr  output  32  byte address of the first fault.
- fault_clr  input  1  synchronous clear of the fault register.

Behaviour:
- Reset values: in_mem = 0, data_in = 0, fault_valid = 0, fault_code = 0, fault_addr = 0. Storage array is not cleared.
- Reset may assert at any time. It takes effect immediately without a clock edge, and any in-flight response is discarded.
- Address decode:
  - misaligned when addr[1:0] != 0;
  - out of range when addr[31:IDX_W+2] != 0;
  - otherwise the word index is addr[IDX_W+1:2].
- Fetch:
  - rising edge with in_mem_en = 1: in_mem <= mem[index].
  - in_mem_en = 0: in_mem holds its previous value.
  - Faulting fetch address: in_mem <= 0 and a fault is raised.
- Load:
  - data_read = 1, data_write = 0: data_in <= mem[index] one cycle later.
  - data_read = 0: data_in holds.
  - Faulting load address: data_in <= 0 and a fault is raised.
- Store:
  - data_write = 1, data_read = 0, legal address: mem[index] <= data_out at the edge.
  - Faulting store address: the write is suppressed and a fault is raised.
- Collision (data_read = 1 and data_write = 1):
  - the store is performed if the address is legal;
  - data_in returns the pre-write (old) word;
  - fault code 11 is raised.
- Read-during-write on the same word through different ports (fetch and store same cycle): the fetch returns the old word (read-before-write).
- Preload:
  - load_en = 1: mem[load_addr] <= load_data at the edge.
  - Preload is accepted even while reset is asserted, because the array is not under reset.
  - While load_en = 1, data_write is ignored (no write, no fault). Loads and fetches proceed normally.
- Fault register:
  - Loads on the first faulting access only, while fault_valid = 0. Later faults are ignored until cleared.
  - Within one cycle, a data-port fault beats a fetch fault.
  - Within one port, cause priority is misaligned > out of range > collision.
  - fault_clr = 1 clears all three fields at the edge. If a new fault occurs in the same cycle, the new fault is captured, i.e. clear then capture.
- No other state machine beyond the fault register (IDLE/FAULTED via fault_valid). Throughput: one fetch plus one data access per cycle, with no stalls.

Test Plan:
- Preload words 0..3 with 0x11111111..0x44444444 during reset. Release reset, then fetch 0x0, 0x4, 0x8 on consecutive cycles -> in_mem = 0x11111111, 0x22222222, 0x33333333 one cycle after each request.
- Store 0xDEADBEEF to 0x10, then load 0x10 on the next cycle -> data_in = 0xDEADBEEF. In the same cycle as the store, fetch 0x10 -> in_mem returns the old word.
- Load from 0x6 -> data_in = 0, fault_valid = 1, fault_code = 01, fault_addr = 0x6. Follow with a load from 0x10000 -> fault fields are unchanged.
- Store to 0x1000 with DEPTH_WORDS = 1024 -> write suppressed, fault_code = 10. Pulse fault_clr -> all fault fields return to 0.
- Assert data_read and data_write to 0x20 (old word 0x5, data_out = 0x9) -> data_in = 0x5, mem[8] = 0x9, fault_code = 11.
- Assert reset asynchronously mid-cycle after a fetch request -> in_mem = 0 and fault_valid = 0 immediately; preloaded contents are intact after release.

Source files
------------

// File: rtl/scc_mem_responder_if.sv
// Bus bundle between the SCC core and its memory responder: fetch port,
// data load/store port, preload port and fault reporting.
interface scc_mem_responder_if #(
  parameter int IDX_W = 10
);
  logic [31:0]      in_mem_addr;
  logic             in_mem_en;
  logic [31:0]      in_mem;
  logic [31:0]      data_addr;
  logic [31:0]      data_out;
  logic             data_read;
  logic             data_write;
  logic [31:0]      data_in;
  logic             load_en;
  logic [IDX_W-1:0] load_addr;
  logic [31:0]      load_data;
  logic             fault_valid;
  logic [1:0]       fault_code;
  logic [31:0]      fault_addr;
  logic             fault_clr;

  modport master (
    output in_mem_addr, in_mem_en, data_addr, data_out, data_read, data_write,
           load_en, load_addr, load_data, fault_clr,
    input  in_mem, data_in, fault_valid, fault_code, fault_addr
  );

  modport slave (
    input  in_mem_addr, in_mem_en, data_addr, data_out, data_read, data_write,
           load_en, load_addr, load_data, fault_clr,
    output in_mem, data_in, fault_valid, fault_code, fault_addr
  );
endinterface

// File: rtl/scc_mem_responder.sv
// Word-addressed memory shared by the SCC fetch and data ports, with
// 1-cycle registered reads, preload writes and a sticky fault register.
//
// state     | meaning
// S_IDLE    | no fault recorded; the next faulting access is captured
// S_FAULTED | first fault held in fault_code/fault_addr until fault_clr
module scc_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic               clk,
  input  logic               reset,
  scc_mem_responder_if.slave bus
);

  typedef enum logic {S_IDLE, S_FAULTED} fault_state_t;

  logic [31:0] mem [DEPTH_WORDS];

  fault_state_t state, state_next;
  logic [1:0]   code_q, code_next;
  logic [31:0]  addr_q, addr_next;
  logic [31:0]  in_mem_q, data_in_q;

  logic             f_mis, f_oor, f_bad;
  logic             d_mis, d_oor, d_bad;
  logic [IDX_W-1:0] f_idx, d_idx;
  logic             d_wr, d_act, st_en;
  logic [1:0]       f_code, d_code;

  assign f_mis = |bus.in_mem_addr[1:0];
  assign f_oor = |bus.in_mem_addr[31:IDX_W+2];
  assign f_bad = f_mis | f_oor;
  assign f_idx = bus.in_mem_addr[IDX_W+1:2];

  assign d_mis = |bus.data_addr[1:0];
  assign d_oor = |bus.data_addr[31:IDX_W+2];
  assign d_bad = d_mis | d_oor;
  assign d_idx = bus.data_addr[IDX_W+1:2];

  // Preload owns the single write port, so a concurrent store is dropped silently.
  assign d_wr  = bus.data_write & ~bus.load_en;
  assign d_act = bus.data_read | d_wr;
  assign st_en = d_wr & ~d_bad;

  always_comb begin
    d_code = 2'b00;
    if (d_act) begin
      if (d_mis)                      d_code = 2'b01;
      else if (d_oor)                 d_code = 2'b10;
      else if (bus.data_read && d_wr) d_code = 2'b11;
    end
  end

  always_comb begin
    f_code = 2'b00;
    if (bus.in_mem_en) begin
      if (f_mis)      f_code = 2'b01;
      else if (f_oor) f_code = 2'b10;
    end
  end

  // Storage is deliberately outside reset so preload works while reset is held.
  always_ff @(posedge clk) begin
    if (bus.load_en) mem[bus.load_addr] <= bus.load_data;
    else if (st_en)  mem[d_idx]         <= bus.data_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_mem_q  <= '0;
      data_in_q <= '0;
    end else begin
      if (bus.in_mem_en) in_mem_q  <= f_bad ? '0 : mem[f_idx];
      if (bus.data_read) data_in_q <= d_bad ? '0 : mem[d_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      code_q <= '0;
      addr_q <= '0;
    end else begin
      state  <= state_next;
      code_q <= code_next;
      addr_q <= addr_next;
    end
  end

  // Clear first, then capture, so a fault arriving with fault_clr is kept.
  always_comb begin
    state_next = state;
    code_next  = code_q;
    addr_next  = addr_q;
    if (bus.fault_clr) begin
      state_next = S_IDLE;
      code_next  = '0;
      addr_next  = '0;
    end
    if (state_next == S_IDLE) begin
      if (d_code != 2'b00) begin
        state_next = S_FAULTED;
        code_next  = d_code;
        addr_next  = bus.data_addr;
      end else if (f_code != 2'b00) begin
        state_next = S_FAULTED;
        code_next  = f_code;
        addr_next  = bus.in_mem_addr;
      end
    end
  end

  assign bus.in_mem      = in_mem_q;
  assign bus.data_in     = data_in_q;
  assign bus.fault_valid = (state == S_FAULTED);
  assign bus.fault_code  = code_q;
  assign bus.fault_addr  = addr_q;

endmodule

// File: tb/tb_scc_mem_responder.sv
// Scoreboard bench for scc_mem_responder: directed scenarios plus random
// traffic checked against a word-array reference model.
module tb_scc_mem_responder;
  localparam int DEPTH = 1024;
  localparam int IDX_W = 10;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  typedef struct {
    logic [31:0] in_mem;
    logic [31:0] data_in;
    logic        fv;
    logic [1:0]  fc;
    logic [31:0] fa;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scc_mem_responder_if #(.IDX_W(IDX_W)) bus ();
  scc_mem_responder #(.DEPTH_WORDS(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];

  logic [31:0] mm [DEPTH];
  logic [31:0] m_in_mem, m_data_in, m_fa;
  logic        m_fv;
  logic [1:0]  m_fc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] addr_cause(input logic [31:0] a);
    if (a % 4 != 0) return 2'd1;
    if (a >= LIMIT) return 2'd2;
    return 2'd0;
  endfunction

  // Reference: one clock edge worth of behaviour using the inputs currently applied.
  task automatic model_step();
    logic [1:0] fcode, dcode;
    logic       d_wr;
    exp_t       e;
    if (reset) begin
      if (bus.load_en) mm[bus.load_addr] = bus.load_data;
      m_in_mem = 0; m_data_in = 0; m_fv = 0; m_fc = 0; m_fa = 0;
    end else begin
      d_wr  = bus.data_write && !bus.load_en;
      fcode = bus.in_mem_en ? addr_cause(bus.in_mem_addr) : 2'd0;
      dcode = 2'd0;
      if (bus.data_read || d_wr) begin
        dcode = addr_cause(bus.data_addr);
        if (dcode == 0 && bus.data_read && d_wr) dcode = 2'd3;
      end
      if (bus.in_mem_en)
        m_in_mem = (addr_cause(bus.in_mem_addr) != 0) ? 32'h0 : mm[bus.in_mem_addr / 4];
      if (bus.data_read)
        m_data_in = (addr_cause(bus.data_addr) != 0) ? 32'h0 : mm[bus.data_addr / 4];
      if (bus.fault_clr) begin m_fv = 0; m_fc = 0; m_fa = 0; end
      if (!m_fv) begin
        if (dcode != 0)      begin m_fv = 1; m_fc = dcode; m_fa = bus.data_addr; end
        else if (fcode != 0) begin m_fv = 1; m_fc = fcode; m_fa = bus.in_mem_addr; end
      end
      if (bus.load_en) mm[bus.load_addr] = bus.load_data;
      else if (d_wr && addr_cause(bus.data_addr) == 0) mm[bus.data_addr / 4] = bus.data_out;
    end
    e.in_mem = m_in_mem; e.data_in = m_data_in; e.fv = m_fv; e.fc = m_fc; e.fa = m_fa;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("in_mem",      bus.in_mem,      e.in_mem);
      chk("data_in",     bus.data_in,     e.data_in);
      chk("fault_valid", 32'(bus.fault_valid), 32'(e.fv));
      chk("fault_code",  32'(bus.fault_code),  32'(e.fc));
      chk("fault_addr",  bus.fault_addr,  e.fa);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_mem_en = 0; bus.data_read = 0; bus.data_write = 0;
    bus.load_en = 0; bus.fault_clr = 0;
  endtask

  task automatic fetch(input logic [31:0] a);
    idle(); bus.in_mem_en = 1; bus.in_mem_addr = a; cyc();
  endtask

  task automatic load(input logic [31:0] a);
    idle(); bus.data_read = 1; bus.data_addr = a; cyc();
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8)  return 32'($urandom_range(0, 63)) * 4;
    if (r == 8) return 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
    return $urandom | 32'h0000_1000;
  endfunction

  initial begin
    reset = 1;
    bus.in_mem_addr = 0; bus.data_addr = 0; bus.data_out = 0;
    bus.load_addr = 0; bus.load_data = 0;
    idle();
    m_in_mem = 0; m_data_in = 0; m_fv = 0; m_fc = 0; m_fa = 0;
    @(negedge clk);
    for (int w = 0; w < 64; w++) begin
      bus.load_en   = 1;
      bus.load_addr = IDX_W'(w);
      if (w < 4)       bus.load_data = 32'h1111_1111 * 32'(w + 1);
      else if (w == 8) bus.load_data = 32'h5;
      else             bus.load_data = $urandom;
      cyc();
    end
    idle(); cyc();
    reset = 0;

    fetch(32'h0); fetch(32'h4); fetch(32'h8);

    idle();
    bus.data_write = 1; bus.data_addr = 32'h10; bus.data_out = 32'hDEAD_BEEF;
    bus.in_mem_en = 1; bus.in_mem_addr = 32'h10;
    cyc();
    load(32'h10);

    load(32'h6);
    load(32'h0001_0000);
    idle(); bus.fault_clr = 1; cyc();

    idle(); bus.data_write = 1; bus.data_addr = 32'h1000; bus.data_out = 32'h1234_5678; cyc();
    idle(); bus.fault_clr = 1; cyc();
    idle(); cyc();

    idle(); bus.data_read = 1; bus.data_write = 1; bus.data_addr = 32'h20; bus.data_out = 32'h9; cyc();
    idle(); bus.fault_clr = 1; cyc();
    load(32'h20);

    idle(); bus.load_en = 1; bus.load_addr = 10'd12; bus.load_data = 32'hCAFE_0012;
    bus.data_write = 1; bus.data_addr = 32'h7; bus.data_out = 32'hBAD0_BAD0; cyc();
    load(32'h30);

    idle(); bus.fault_clr = 1; bus.data_read = 1; bus.data_addr = 32'h2; cyc();

    for (int i = 0; i < 400; i++) begin
      idle();
      bus.in_mem_en   = ($urandom_range(0, 1) == 1);
      bus.in_mem_addr = rand_addr();
      bus.data_read   = ($urandom_range(0, 1) == 1);
      bus.data_write  = ($urandom_range(0, 2) == 0);
      bus.data_addr   = rand_addr();
      bus.data_out    = $urandom;
      bus.load_en     = ($urandom_range(0, 9) == 0);
      bus.load_addr   = IDX_W'($urandom_range(0, 63));
      bus.load_data   = $urandom;
      bus.fault_clr   = ($urandom_range(0, 7) == 0);
      cyc();
    end

    load(32'h6);
    fetch(32'h4);
    idle(); bus.in_mem_en = 1; bus.in_mem_addr = 32'h4;
    @(posedge clk); #1;
    model_step();
    #2;
    reset = 1;
    exp_q.delete();
    m_in_mem = 0; m_data_in = 0; m_fv = 0; m_fc = 0; m_fa = 0;
    #1;
    chk("async_reset_in_mem",      bus.in_mem, 32'h0);
    chk("async_reset_data_in",     bus.data_in, 32'h0);
    chk("async_reset_fault_valid", 32'(bus.fault_valid), 32'h0);
    @(negedge clk);
    idle(); cyc(); cyc();
    reset = 0;
    fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC); fetch(32'h20);
    idle(); cyc(); cyc();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
